// File: rtl/fsm_pkg.sv
// Shared types for the serial pattern generator and the sequence detector bench.
// Opcodes, engine states and the per-opcode helpers live here.
package fsm_pkg;

    localparam int unsigned LEN_W_DEF = 4;
    localparam int unsigned MARK_BITS = 3;

    typedef enum logic [1:0] {
        OP_ZERO = 2'd0,
        OP_ONE  = 2'd1,
        OP_MARK = 2'd2,
        OP_ALT  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ZERO,
        S_ONE,
        S_MRK0,
        S_MRK1,
        S_MRK2,
        S_ALT
    } state_e;

    function automatic state_e op_state(input op_e op);
        case (op)
            OP_ZERO: return S_ZERO;
            OP_ONE:  return S_ONE;
            OP_MARK: return S_MRK0;
            default: return S_ALT;
        endcase
    endfunction

    // ALT starts on 1; MARK starts on 0.
    function automatic logic op_first_bit(input op_e op);
        return (op == OP_ONE) || (op == OP_ALT);
    endfunction

endpackage

// File: rtl/fsm_cmd_slot.sv
// One-entry command holding register between the stimulus controller and the engine.
// Ready depends only on slot occupancy and the engine's load, never on cmd_valid.
module fsm_cmd_slot
    import fsm_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  op_e              cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             load,
    output logic             slot_v,
    output op_e              slot_op,
    output logic [LEN_W-1:0] slot_len
);

    assign cmd_ready = !rst && (!slot_v || load);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_v   <= 1'b0;
            slot_op  <= OP_ZERO;
            slot_len <= '0;
        end else if (cmd_valid && cmd_ready) begin
            slot_v   <= 1'b1;
            slot_op  <= cmd_op;
            slot_len <= cmd_len;
        end else if (load) begin
            slot_v   <= 1'b0;
        end
    end

endmodule

// File: rtl/fsm_pattern_gen.sv
// Serial pattern transmitter: serializes queued opcode+length commands one bit per clock.
// State and output flops describe the bit currently on ser_out; next values are computed ahead.
module fsm_pattern_gen
    import fsm_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  op_e              cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             cmd_done,
    output logic             busy
);

    state_e           state, state_nx;
    logic [LEN_W-1:0] cnt, cnt_nx, cnt_dec;
    logic             bit_nx, valid_nx, done_nx;
    logic             last, load;
    logic             slot_v;
    op_e              slot_op;
    logic [LEN_W-1:0] slot_len;

    fsm_cmd_slot #(.LEN_W(LEN_W)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .load      (load),
        .slot_v    (slot_v),
        .slot_op   (slot_op),
        .slot_len  (slot_len)
    );

    assign cnt_dec = cnt - LEN_W'(1);
    assign load    = slot_v && ((state == S_IDLE) || last);
    assign busy    = ser_valid || slot_v;

    always_comb begin
        last = 1'b0;
        case (state)
            S_ZERO, S_ONE, S_ALT: last = (cnt == '0);
            S_MRK2:               last = 1'b1;
            default:              last = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        bit_nx   = 1'b0;
        valid_nx = 1'b0;
        done_nx  = 1'b0;
        if (load) begin
            state_nx = op_state(slot_op);
            cnt_nx   = slot_len;
            bit_nx   = op_first_bit(slot_op);
            valid_nx = 1'b1;
            done_nx  = (slot_op != OP_MARK) && (slot_len == '0);
        end else if (last || (state == S_IDLE)) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
        end else begin
            valid_nx = 1'b1;
            case (state)
                S_ZERO: begin
                    cnt_nx  = cnt_dec;
                    done_nx = (cnt_dec == '0);
                end
                S_ONE: begin
                    cnt_nx  = cnt_dec;
                    bit_nx  = 1'b1;
                    done_nx = (cnt_dec == '0);
                end
                S_ALT: begin
                    cnt_nx  = cnt_dec;
                    bit_nx  = !ser_out;
                    done_nx = (cnt_dec == '0);
                end
                S_MRK0: begin
                    state_nx = S_MRK1;
                    bit_nx   = 1'b1;
                end
                S_MRK1: begin
                    state_nx = S_MRK2;
                    done_nx  = 1'b1;
                end
                default: begin
                    state_nx = S_IDLE;
                    valid_nx = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            cmd_done  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ser_out   <= bit_nx;
            ser_valid <= valid_nx;
            cmd_done  <= done_nx;
        end
    end

endmodule

// File: tb/tb_fsm_pattern_gen.sv
// Bench for fsm_pattern_gen: directed and random commands checked every cycle against
// a timeline model that places each accepted command's bits at absolute cycle indices.
module tb_fsm_pattern_gen;
    import fsm_pkg::*;

    localparam int unsigned LEN_W = 4;
    localparam int unsigned DEPTH = 4096;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    op_e              cmd_op = OP_ZERO;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             cmd_ready, ser_out, ser_valid, cmd_done, busy;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc = 0;
    int unsigned next_free = 0;
    int unsigned slot_start = 0;
    logic        exp_bit [DEPTH];
    logic        exp_vld [DEPTH];
    logic        exp_done[DEPTH];

    fsm_pattern_gen #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .cmd_done  (cmd_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d: got %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int unsigned i;
        i = (cyc < DEPTH) ? cyc : DEPTH - 1;
        chk("ser_valid", ser_valid, exp_vld[i]);
        chk("ser_out", ser_out, exp_bit[i]);
        chk("cmd_done", cmd_done, exp_done[i]);
        chk("cmd_ready", cmd_ready, !rst && (cyc + 1 >= slot_start));
        chk("busy", busy, exp_vld[i] || (slot_start > cyc));
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic model_bit(input op_e op, input int unsigned i);
        case (op)
            OP_ZERO: return 1'b0;
            OP_ONE:  return 1'b1;
            OP_MARK: return (i == 1);
            default: return (i % 2 == 0);
        endcase
    endfunction

    // Command accepted at acc_edge starts right after the previous one, but never before acc_edge+1.
    task automatic schedule(input int unsigned acc_edge, input op_e op, input logic [LEN_W-1:0] len);
        int unsigned k, start;
        k     = (op == OP_MARK) ? MARK_BITS : int'(len) + 1;
        start = (acc_edge + 1 > next_free) ? acc_edge + 1 : next_free;
        for (int unsigned i = 0; i < k; i++) begin
            if (start + i < DEPTH) begin
                exp_bit[start + i]  = model_bit(op, i);
                exp_vld[start + i]  = 1'b1;
                exp_done[start + i] = (i == k - 1);
            end
        end
        next_free  = start + k;
        slot_start = start;
    endtask

    task automatic send(input op_e op, input logic [LEN_W-1:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        for (int w = 0; w < 100; w++) begin
            if (!rst && (cyc + 1 >= slot_start)) begin
                schedule(cyc + 1, op, len);
                tick();
                cmd_valid = 1'b0;
                return;
            end
            tick();
        end
        tests++;
        fails++;
        $display("FAIL send_timeout cyc=%0d: command not accepted within 100 cycles", cyc);
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drain();
        for (int w = 0; w < 200 && cyc < next_free + 1; w++) tick();
    endtask

    task automatic clear_model();
        for (int unsigned i = cyc; i < DEPTH; i++) begin
            exp_bit[i]  = 1'b0;
            exp_vld[i]  = 1'b0;
            exp_done[i] = 1'b0;
        end
        next_free  = 0;
        slot_start = 0;
    endtask

    // Reset lands mid-cycle; outputs must fall before the next clock edge.
    task automatic reset_mid();
        #2 rst = 1'b1;
        #1;
        clear_model();
        check_outputs();
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            exp_bit[i]  = 1'b0;
            exp_vld[i]  = 1'b0;
            exp_done[i] = 1'b0;
        end
        idle(2);
        rst = 1'b0;
        idle(1);

        send(OP_ONE, 4'd2);
        drain();

        send(OP_MARK, 4'd9);
        send(OP_ONE, 4'd2);
        drain();

        send(OP_ALT, 4'd4);
        drain();
        send(OP_ZERO, 4'd0);
        drain();
        send(OP_ALT, 4'd15);
        send(OP_ONE, 4'd0);
        drain();

        send(OP_ZERO, 4'd3);
        send(OP_ALT, 4'd5);
        send(OP_MARK, 4'd7);
        drain();

        send(OP_ONE, 4'd15);
        send(OP_ZERO, 4'd3);
        idle(4);
        reset_mid();
        idle(3);
        send(OP_ONE, 4'd1);
        drain();

        for (int n = 0; n < 60; n++) begin
            op_e              op;
            logic [LEN_W-1:0] len;
            int unsigned      sel;
            op  = op_e'($urandom_range(0, 3));
            sel = $urandom_range(0, 7);
            len = (sel == 0) ? '0 : (sel == 1) ? '1 : LEN_W'($urandom_range(0, 15));
            idle($urandom_range(0, 2));
            send(op, len);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
